// File: rtl/cnn_mem_loader.sv
// cnn_mem_loader: moves a counted run of stream words into consecutive CNN memory addresses.
// Optional running checksum of the loaded words when CNN_LOADER_CHECKSUM_EN is defined.
`default_nettype none

module cnn_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_base,
  input  logic [CNT_W-1:0]  i_cmd_count,
  input  logic              i_abort,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data_in,
  output logic              o_mem_write_enable,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wrap_err
`ifdef CNN_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_checksum
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_data;
  logic               r_mem_we;
  logic               r_wrap_err;
  logic               w_cmd_acc;
  logic               w_s_ready;
  logic               w_beat;

  assign w_cmd_acc = (r_state == ST_IDLE) && i_cmd_valid;
  // A beat offered alongside abort must not be taken.
  assign w_s_ready = (r_state == ST_LOAD) && !i_abort;
  assign w_beat    = w_s_ready && i_s_valid;

  assign o_cmd_ready        = (r_state == ST_IDLE);
  assign o_s_ready          = w_s_ready;
  assign o_busy             = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign o_done             = (r_state == ST_DONE);
  assign o_mem_address      = r_mem_addr;
  assign o_mem_data_in      = r_mem_data;
  assign o_mem_write_enable = r_mem_we;
  assign o_wrap_err         = r_wrap_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_state_nxt = (i_cmd_count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (i_s_valid && (r_remaining == CNT_W'(1))) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = i_abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_we    <= 1'b0;
      r_wrap_err  <= 1'b0;
    end else begin
      r_mem_we <= w_beat;
      if (w_cmd_acc) begin
        r_addr      <= i_cmd_base;
        r_remaining <= i_cmd_count;
        r_wrap_err  <= 1'b0;
      end else if (w_beat) begin
        r_mem_addr  <= r_addr;
        r_mem_data  <= i_s_data;
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
        if (&r_addr) begin
          r_wrap_err <= 1'b1;
        end
      end
    end
  end

`ifdef CNN_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_cmd_acc) begin
      r_checksum <= '0;
    end else if (w_beat) begin
      r_checksum <= r_checksum + i_s_data;
    end
  end

  assign o_checksum = r_checksum;
`endif

endmodule

`default_nettype wire
